vga_frame_scheduler: RTL and testbench
======================================

Name: vga_frame_scheduler

Overview:
- Frame-level controller between the video sync generator and the pixel colour path.
- Generates active-area pixel coordinates with counters, so no per-pixel divide or modulo is needed.
- Samples screen, mistake and sensor inputs once per frame so values stay stable across a frame.
- Runs the splash/play/mistake-flash display sequence and classifies each pad's distance into a colour zone for the overlay mux.

Parameters:
H_ACTIVE, 640, active pixels per line
V_ACTIVE, 480, active lines per frame
ZONE1_MAX, 40, distances 1..ZONE1_MAX-1 map to zone 1
ZONE2_MAX, 80, distances ZONE1_MAX..ZONE2_MAX-1 map to zone 2
ZONE3_MAX, 120, distances ZONE2_MAX..ZONE3_MAX-1 map to zone 3
FLASH_FRAMES, 60, frames spent in mistake state
FLASH_PERIOD, 8, frames per flash_on half-period

Ports:
vga_clk  in  1  pixel clock; all logic on rising edge
reset  in  1  asynchronous, active-high reset
hs  in  1  horizontal sync, active low
vs  in  1  vertical sync, active low
blank_n  in  1  high during active video
screen  in  32  screen select; zero means "no update"
mistake  in  32  mistake counter from processor
sensor_in  in  32  pad distances: [6:0] pad0, [13:7] pad1, [20:14] pad2
x  out  10  active pixel column
y  out  10  active pixel row
pixel_valid  out  1  registered copy of blank_n, aligned with x/y
frame_start  out  1  one-cycle pulse on vs falling edge
splash_sel  out  1  1 selects splash image index
mode  out  2  0 = SPLASH, 1 = PLAY, 2 = MISTAKE
flash_on  out  1  mistake flash phase
pad_zone  out  6  2 bits per pad, pad0 in [1:0]
sensor_latched  out  21  frame-stable distances

Behaviour:
- Reset values: all outputs 0, except splash_sel = 1. Internal registers: screen_q = 0, mistake_q = 0, frame counter = 0, state = SPLASH.
- Edge detect: vs_d is a registered copy of vs. frame_start = vs_d & ~vs, registered, so it asserts 1 cycle after the vs falling edge.
- Pixel counters:
  - On frame_start: x = 0, y = 0.
  - Otherwise, when blank_n = 1, x increments.
  - When x = H_ACTIVE-1 with blank_n = 1: x wraps to 0 and y increments.
  - y saturates at V_ACTIVE-1.
  - When blank_n = 0, x and y hold.
  - x, y and pixel_valid share one cycle of latency from blank_n.
- Frame sampling (frame_start cycle only):
  - sensor_latched <= sensor_in[20:0].
  - screen_q <= screen if screen != 0; otherwise screen_q holds (sticky).
  - mistake_q <= mistake.
  - All other cycles hold these values.
- Zone classification: registered, updated in the cycle after frame_start from sensor_latched, per pad d:
  - d = 0 -> 0
  - 1 <= d < ZONE1_MAX -> 1
  - ZONE1_MAX <= d < ZONE2_MAX -> 2
  - ZONE2_MAX <= d < ZONE3_MAX -> 3
  - d >= ZONE3_MAX -> 0
  - Boundary cases: d = 40 -> 2, d = 80 -> 3, d = 120 -> 0.
- State machine: transitions are evaluated only on frame_start, using the values sampled in that same cycle.
  - SPLASH -> PLAY when screen[9:0] != 0 (new sample, or screen_q if screen = 0).
  - PLAY -> MISTAKE when mistake != mistake_q and mistake != 0. This clears fcnt to 0 and sets flash_on = 1.
  - MISTAKE:
    - fcnt increments each frame.
    - flash_on toggles when fcnt mod FLASH_PERIOD = FLASH_PERIOD-1.
    - At fcnt = FLASH_FRAMES-1: go to PLAY, flash_on = 0.
  - MISTAKE, new mistake change: fcnt restarts at 0, flash_on = 1.
  - Any state, screen[9:0] sampled as 0 after having been nonzero: impossible due to the sticky rule; SPLASH is re-entered only by reset.
- splash_sel = (mode == SPLASH), registered.
- Reset mid-frame: immediate return to reset values. Counters restart correctly at the next frame_start. x/y are undefined-but-bounded until then (they may count from 0).
- All arithmetic is unsigned. Comparisons are 7-bit for distances, 10-bit for coordinates.

Optional Feature:
- Macro: SENSOR_DEBOUNCE_EN.
- Defined: a pad's zone output changes only when the same candidate zone is computed on 2 consecutive frames. Per-pad 2-bit candidate register plus 1-bit agree flag; reset clears both to 0.
- Undefined: the zone updates every frame as above, with no extra registers.

Test Plan:
- Reset, then 3 frames (640x480 active) -> x reaches 639 and wraps; y reaches 479; frame_start has exactly 1 pulse per frame; mode = 0 and splash_sel = 1 throughout.
- sensor_in = {7'd90, 7'd40, 7'd25} held 2 frames -> sensor_latched changes only at frame_start; pad_zone = 6'b11_10_01. Then pads {0, 120, 119} -> pad_zone = 6'b11_00_00 next frame.
- screen = 1 for one cycle mid-frame, then 0 -> no change until frame_start; screen pulsed again during the frame_start cycle -> mode = 1 after that frame; screen = 0 afterward keeps mode = 1.
- In PLAY, mistake 0 -> 3 -> mode = 2 at next frame_start; flash_on toggles every 8 frames; mode = 1 and flash_on = 0 after 60 frames. mistake 3 -> 4 at frame 20 -> 60-frame window restarts.
- Assert reset at x = 300, y = 200 -> all outputs 0 and splash_sel = 1 asynchronously; after release, x = 0 and y = 0 on the first frame_start.
- With SENSOR_DEBOUNCE_EN, pad0 distances 25, 50, 50 over 3 frames -> pad_zone[1:0] = 0, 0, 2. Without the macro -> 1, 2, 2.

Source files
------------

// File: rtl/vga_frame_scheduler.sv
// Frame-level controller: pixel coordinates, per-frame input sampling, display state sequencing and pad zone classification.
// Optional build macro SENSOR_DEBOUNCE_EN: a pad zone changes only after two consecutive frames agree on it.
module vga_frame_scheduler #(
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int ZONE1_MAX    = 40,
  parameter int ZONE2_MAX    = 80,
  parameter int ZONE3_MAX    = 120,
  parameter int FLASH_FRAMES = 60,
  parameter int FLASH_PERIOD = 8
) (
  input  logic        vga_clk,
  input  logic        reset,
  input  logic        hs,
  input  logic        vs,
  input  logic        blank_n,
  input  logic [31:0] screen,
  input  logic [31:0] mistake,
  input  logic [31:0] sensor_in,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        pixel_valid,
  output logic        frame_start,
  output logic        splash_sel,
  output logic [1:0]  mode,
  output logic        flash_on,
  output logic [5:0]  pad_zone,
  output logic [20:0] sensor_latched
);

  localparam int FC_W = $clog2(FLASH_FRAMES + 1);
  localparam int PC_W = $clog2(FLASH_PERIOD + 1);
  localparam logic [9:0]      X_LAST = 10'(H_ACTIVE - 1);
  localparam logic [9:0]      Y_LAST = 10'(V_ACTIVE - 1);
  localparam logic [6:0]      Z1     = 7'(ZONE1_MAX);
  localparam logic [6:0]      Z2     = 7'(ZONE2_MAX);
  localparam logic [6:0]      Z3     = 7'(ZONE3_MAX);
  localparam logic [FC_W-1:0] F_LAST = FC_W'(FLASH_FRAMES - 1);
  localparam logic [PC_W-1:0] P_LAST = PC_W'(FLASH_PERIOD - 1);

  typedef enum logic [1:0] {
    SPLASH  = 2'd0,
    PLAY    = 2'd1,
    MISTAKE = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [FC_W-1:0] fcnt, fcnt_n;
  logic [PC_W-1:0] pcnt, pcnt_n;
  logic            flash_n;
  logic            vs_p0;
  logic            fs_p1;
  logic [9:0]      hc, vc;
  logic [9:0]      screen_q;
  logic [31:0]     mistake_q;
  logic [9:0]      screen_eff;
  logic            mistake_chg;
  logic [5:0]      zone_c;

  // Sync and the upper sensor bits carry nothing this block needs.
  logic unused_inputs;
  assign unused_inputs = &{1'b0, hs, sensor_in[31:21]};

  function automatic logic [1:0] zone_of(input logic [6:0] d);
    if (d == 7'd0)   return 2'd0;
    else if (d < Z1) return 2'd1;
    else if (d < Z2) return 2'd2;
    else if (d < Z3) return 2'd3;
    else             return 2'd0;
  endfunction

  // Stage p0: vs edge detect, frame_start one cycle after the falling edge
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      vs_p0       <= 1'b0;
      frame_start <= 1'b0;
      fs_p1       <= 1'b0;
    end else begin
      vs_p0       <= vs;
      frame_start <= vs_p0 & ~vs;
      fs_p1       <= frame_start;
    end
  end

  // hc/vc hold the coordinate of the next active pixel; x/y carry the current one
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      hc          <= '0;
      vc          <= '0;
      x           <= '0;
      y           <= '0;
      pixel_valid <= 1'b0;
    end else begin
      pixel_valid <= blank_n;
      if (frame_start) begin
        hc <= '0;
        vc <= '0;
        x  <= '0;
        y  <= '0;
      end else if (blank_n) begin
        x <= hc;
        y <= vc;
        if (hc == X_LAST) begin
          hc <= '0;
          if (vc != Y_LAST) vc <= vc + 10'd1;
        end else begin
          hc <= hc + 10'd1;
        end
      end
    end
  end

  assign screen_eff  = (screen != 32'd0) ? screen[9:0] : screen_q;
  assign mistake_chg = (mistake != mistake_q) && (mistake != 32'd0);

  // Stage p1: frame-stable samples of the processor and sensor inputs
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      screen_q       <= '0;
      mistake_q      <= '0;
      sensor_latched <= '0;
    end else if (frame_start) begin
      if (screen != 32'd0) screen_q <= screen[9:0];
      mistake_q      <= mistake;
      sensor_latched <= sensor_in[20:0];
    end
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      state      <= SPLASH;
      fcnt       <= '0;
      pcnt       <= '0;
      flash_on   <= 1'b0;
      splash_sel <= 1'b1;
    end else begin
      state      <= state_n;
      fcnt       <= fcnt_n;
      pcnt       <= pcnt_n;
      flash_on   <= flash_n;
      splash_sel <= (state == SPLASH);
    end
  end

  always_comb begin
    state_n = state;
    fcnt_n  = fcnt;
    pcnt_n  = pcnt;
    flash_n = flash_on;
    if (frame_start) begin
      case (state)
        SPLASH: begin
          if (screen_eff != 10'd0) state_n = PLAY;
        end
        PLAY: begin
          if (mistake_chg) begin
            state_n = MISTAKE;
            fcnt_n  = '0;
            pcnt_n  = '0;
            flash_n = 1'b1;
          end
        end
        MISTAKE: begin
          if (mistake_chg) begin
            fcnt_n  = '0;
            pcnt_n  = '0;
            flash_n = 1'b1;
          end else if (fcnt == F_LAST) begin
            state_n = PLAY;
            fcnt_n  = '0;
            pcnt_n  = '0;
            flash_n = 1'b0;
          end else begin
            fcnt_n = fcnt + 1'b1;
            // pcnt tracks fcnt mod FLASH_PERIOD without a divider
            if (pcnt == P_LAST) begin
              pcnt_n  = '0;
              flash_n = ~flash_on;
            end else begin
              pcnt_n = pcnt + 1'b1;
            end
          end
        end
        default: state_n = SPLASH;
      endcase
    end
  end

  assign mode = state;

  assign zone_c = {zone_of(sensor_latched[20:14]),
                   zone_of(sensor_latched[13:7]),
                   zone_of(sensor_latched[6:0])};

`ifdef SENSOR_DEBOUNCE_EN
  logic [5:0] cand_p1;
  logic [2:0] agree_p1;
  logic       fs_p2;

  // Stage p2: candidate compared against last frame's, zone commits one cycle later
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      cand_p1  <= '0;
      agree_p1 <= '0;
      fs_p2    <= 1'b0;
      pad_zone <= '0;
    end else begin
      fs_p2 <= fs_p1;
      if (fs_p1) begin
        cand_p1 <= zone_c;
        for (int i = 0; i < 3; i++)
          agree_p1[i] <= (zone_c[2*i +: 2] == cand_p1[2*i +: 2]);
      end
      if (fs_p2) begin
        for (int i = 0; i < 3; i++)
          if (agree_p1[i]) pad_zone[2*i +: 2] <= cand_p1[2*i +: 2];
      end
    end
  end
`else
  // Stage p2: zone refresh from the freshly latched distances
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      pad_zone <= '0;
    end else if (fs_p1) begin
      pad_zone <= zone_c;
    end
  end
`endif

endmodule

// File: tb/tb_vga_frame_scheduler.sv
// Scoreboard bench for vga_frame_scheduler on a reduced 16x6 raster; expectations follow SENSOR_DEBOUNCE_EN.
module tb_vga_frame_scheduler;

  localparam int H = 16;
  localparam int V = 6;
`ifdef SENSOR_DEBOUNCE_EN
  localparam bit DEB_EN = 1'b1;
`else
  localparam bit DEB_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        hs = 1'b1;
  logic        vs = 1'b1;
  logic        blank_n = 1'b0;
  logic [31:0] screen = '0;
  logic [31:0] mistake = '0;
  logic [31:0] sensor_in = '0;
  logic [9:0]  x, y;
  logic        pixel_valid, frame_start, splash_sel, flash_on;
  logic [1:0]  mode;
  logic [5:0]  pad_zone;
  logic [20:0] sensor_latched;

  vga_frame_scheduler #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .vga_clk(clk), .reset(reset), .hs(hs), .vs(vs), .blank_n(blank_n),
    .screen(screen), .mistake(mistake), .sensor_in(sensor_in),
    .x(x), .y(y), .pixel_valid(pixel_valid), .frame_start(frame_start),
    .splash_sel(splash_sel), .mode(mode), .flash_on(flash_on),
    .pad_zone(pad_zone), .sensor_latched(sensor_latched)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
  } pix_t;

  typedef struct packed {
    logic [1:0]  m;
    logic        s;
    logic        f;
    logic [5:0]  pz;
    logic [20:0] sl;
  } frec_t;

  pix_t  pq[$];
  frec_t fq[$];
  int    total = 0;
  int    bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] pz_pick(input logic [5:0] plain, input logic [5:0] deb);
    return DEB_EN ? deb : plain;
  endfunction

  task automatic exp_frame(input logic [1:0] m, input logic s, input logic f,
                           input logic [5:0] pz, input logic [20:0] sl);
    frec_t r;
    r.m = m; r.s = s; r.f = f; r.pz = pz; r.sl = sl;
    fq.push_back(r);
  endtask

  task automatic drive_pixels(input int l, input int ncols);
    pix_t p;
    for (int c = 0; c < ncols; c++) begin
      blank_n = 1'b1;
      hs = 1'b1;
      p.x = 10'(c);
      p.y = (l < V) ? 10'(l) : 10'(V - 1);
      pq.push_back(p);
      tick;
    end
    blank_n = 1'b0;
  endtask

  task automatic run_frame(input logic [31:0] scr_fs, input bit mid_pulse, input int nlines);
    vs = 1'b0;
    tick;
    screen = scr_fs;
    tick;
    screen = '0;
    tick;
    vs = 1'b1;
    repeat (3) tick;
    for (int l = 0; l < nlines; l++) begin
      drive_pixels(l, H);
      hs = 1'b0;
      if (mid_pulse && l == 2) begin
        screen = 32'd1;
        tick;
        screen = '0;
      end
      repeat (4) tick;
      hs = 1'b1;
    end
    repeat (4) tick;
  endtask

  // Pixel monitor: every valid pixel must match the next expected coordinate
  initial begin
    pix_t p;
    forever begin
      @(negedge clk);
      if (pixel_valid === 1'b1) begin
        if (pq.size() == 0) begin
          chk("pix_unexpected", 32'(pixel_valid), 32'd0);
        end else begin
          p = pq.pop_front();
          chk("pix_x", 32'(x), 32'(p.x));
          chk("pix_y", 32'(y), 32'(p.y));
        end
      end
    end
  end

  // Frame monitor: on each frame_start, check pulse width and the settled frame state
  initial begin
    frec_t r;
    forever begin
      @(negedge clk);
      if (frame_start === 1'b1) begin
        if (fq.size() == 0) begin
          chk("fs_unexpected", 32'(frame_start), 32'd0);
        end else begin
          r = fq.pop_front();
          @(negedge clk);
          chk("fs_width", 32'(frame_start), 32'd0);
          repeat (3) @(negedge clk);
          chk("mode", 32'(mode), 32'(r.m));
          chk("splash_sel", 32'(splash_sel), 32'(r.s));
          chk("flash_on", 32'(flash_on), 32'(r.f));
          chk("pad_zone", 32'(pad_zone), 32'(r.pz));
          chk("sensor_latched", 32'(sensor_latched), 32'(r.sl));
          chk("x_at_fs", 32'(x), 32'd0);
          chk("y_at_fs", 32'(y), 32'd0);
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [20:0] s1, s2, s3, s4, s5;
    s1 = {7'd90, 7'd40, 7'd25};
    s2 = {7'd119, 7'd120, 7'd0};
    s3 = {7'd119, 7'd120, 7'd25};
    s4 = {7'd119, 7'd120, 7'd50};
    s5 = {7'd127, 7'd80, 7'd1};

    repeat (3) tick;
    chk("rst_x", 32'(x), 32'd0);
    chk("rst_y", 32'(y), 32'd0);
    chk("rst_pv", 32'(pixel_valid), 32'd0);
    chk("rst_fs", 32'(frame_start), 32'd0);
    chk("rst_splash", 32'(splash_sel), 32'd1);
    chk("rst_mode", 32'(mode), 32'd0);
    chk("rst_flash", 32'(flash_on), 32'd0);
    chk("rst_pz", 32'(pad_zone), 32'd0);
    chk("rst_sl", 32'(sensor_latched), 32'd0);
    reset = 1'b0;
    repeat (4) tick;

    exp_frame(2'd0, 1'b1, 1'b0, 6'd0, 21'd0);
    run_frame('0, 1'b0, V);
    exp_frame(2'd0, 1'b1, 1'b0, 6'd0, 21'd0);
    run_frame('0, 1'b0, V + 1);

    sensor_in = 32'(s1);
    repeat (2) tick;
    chk("sl_hold_midframe", 32'(sensor_latched), 32'd0);
    exp_frame(2'd0, 1'b1, 1'b0, pz_pick(6'b11_10_01, 6'b00_00_00), s1);
    run_frame('0, 1'b0, V);
    exp_frame(2'd0, 1'b1, 1'b0, 6'b11_10_01, s1);
    run_frame('0, 1'b0, V);

    sensor_in = 32'(s2);
    exp_frame(2'd0, 1'b1, 1'b0, pz_pick(6'b11_00_00, 6'b11_10_01), s2);
    run_frame('0, 1'b0, V);
    exp_frame(2'd0, 1'b1, 1'b0, 6'b11_00_00, s2);
    run_frame('0, 1'b0, V);

    sensor_in = 32'(s3);
    exp_frame(2'd0, 1'b1, 1'b0, pz_pick(6'b11_00_01, 6'b11_00_00), s3);
    run_frame('0, 1'b0, V);
    sensor_in = 32'(s4);
    exp_frame(2'd0, 1'b1, 1'b0, pz_pick(6'b11_00_10, 6'b11_00_00), s4);
    run_frame('0, 1'b1, V);
    exp_frame(2'd0, 1'b1, 1'b0, 6'b11_00_10, s4);
    run_frame('0, 1'b0, V);

    sensor_in = 32'(s5);
    exp_frame(2'd1, 1'b0, 1'b0, pz_pick(6'b00_11_01, 6'b11_00_10), s5);
    run_frame(32'd1, 1'b0, V);
    exp_frame(2'd1, 1'b0, 1'b0, 6'b00_11_01, s5);
    run_frame('0, 1'b0, V);

    mistake = 32'd3;
    exp_frame(2'd2, 1'b0, 1'b1, 6'b00_11_01, s5);
    run_frame('0, 1'b0, V);
    for (int k = 1; k < 20; k++) begin
      exp_frame(2'd2, 1'b0, ((k / 8) % 2) == 0, 6'b00_11_01, s5);
      run_frame('0, 1'b0, V);
    end
    mistake = 32'd4;
    exp_frame(2'd2, 1'b0, 1'b1, 6'b00_11_01, s5);
    run_frame('0, 1'b0, V);
    for (int j = 1; j < 60; j++) begin
      exp_frame(2'd2, 1'b0, ((j / 8) % 2) == 0, 6'b00_11_01, s5);
      run_frame('0, 1'b0, V);
    end
    for (int j = 0; j < 3; j++) begin
      exp_frame(2'd1, 1'b0, 1'b0, 6'b00_11_01, s5);
      run_frame('0, 1'b0, V);
    end

    exp_frame(2'd1, 1'b0, 1'b0, 6'b00_11_01, s5);
    vs = 1'b0;
    tick;
    tick;
    vs = 1'b1;
    repeat (3) tick;
    for (int l = 0; l < 3; l++) begin
      drive_pixels(l, H);
      repeat (4) tick;
    end
    drive_pixels(3, 5);
    #1;
    reset = 1'b1;
    blank_n = 1'b0;
    pq.delete();
    #1;
    chk("mid_rst_x", 32'(x), 32'd0);
    chk("mid_rst_y", 32'(y), 32'd0);
    chk("mid_rst_pv", 32'(pixel_valid), 32'd0);
    chk("mid_rst_splash", 32'(splash_sel), 32'd1);
    chk("mid_rst_mode", 32'(mode), 32'd0);
    chk("mid_rst_flash", 32'(flash_on), 32'd0);
    chk("mid_rst_pz", 32'(pad_zone), 32'd0);
    chk("mid_rst_sl", 32'(sensor_latched), 32'd0);
    repeat (3) tick;
    reset = 1'b0;
    repeat (3) tick;
    exp_frame(2'd0, 1'b1, 1'b0, pz_pick(6'b00_11_01, 6'b00_00_00), s5);
    run_frame('0, 1'b0, V);

    repeat (10) tick;
    chk("pix_q_empty", 32'(pq.size()), 32'd0);
    chk("frm_q_empty", 32'(fq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
